// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder for the MEM stage.
// A request seen in IDLE is latched, held for LAT cycles with stall high,
// and committed on the edge that enters DONE (write into storage, or load
// into rd_data with a one-cycle rd_vld pulse). The pipeline advances on
// the DONE edge, so the request still visible during DONE is never re-accepted.
module dmem_resp #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rd_vld,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;

    // Access port seen on the commit edge: live inputs when LAT==1 commits
    // straight out of IDLE, latched values otherwise.
    logic              commit;
    logic              stall_c;
    logic [ADDR_W-1:0] acc_addr;
    logic [15:0]       acc_data;
    logic              acc_wr;
    logic              mem_we;

    logic [15:0]       mem_q [2**ADDR_W];

    // Upper address bits alias away by design.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_W];

    // Next-state, request latching and commit decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        stall_c   = 1'b0;
        commit    = 1'b0;
        acc_addr  = addr_q;
        acc_data  = data_q;
        acc_wr    = wr_q;
        case (state_q)
            IDLE: begin
                stall_c  = re | we;
                acc_addr = addr[ADDR_W-1:0];
                acc_data = wrt_data;
                acc_wr   = we;
                if (re | we) begin
                    addr_d = addr[ADDR_W-1:0];
                    data_d = wrt_data;
                    wr_d   = we;
                    cnt_d  = LAT_M1;
                    if (LAT > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_vld_d  = commit & ~acc_wr;
        rd_data_d = rd_vld_d ? mem_q[acc_addr] : rd_data_q;
    end

    // A write is never performed while reset is asserted, so an aborted
    // access leaves storage untouched.
    assign mem_we = commit & acc_wr & rst_n;

    // Stall is gated by rst_n so it falls the moment reset is applied.
    assign stall   = stall_c & rst_n;
    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= 16'h0000;
            wr_q      <= 1'b0;
            rd_data_q <= 16'h0000;
            rd_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Storage write port, committed on the edge entering DONE.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; contents survive rst_n and the array maps onto plain RAM.
        if (mem_we) begin
            mem_q[acc_addr] <= acc_data;
        end
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Multi-cycle data-memory responder on the CPU load/store port: addr, re, we, wrt_data in; rd_data out.
- Adds a fixed, programmable access latency and a stall handshake back to the pipeline, so MEM-stage accesses can model slow memory.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Holds a word-addressed 16-bit storage array internally.

Parameters:
- ADDR_W, 12, index bits of storage; depth is 2^ADDR_W words; addr[15:ADDR_W] ignored.
- LAT, 3, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  global clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- addr  input  16  word address from EX/MEM result.
- re  input  1  read request.
- we  input  1  write request.
- wrt_data  input  16  store data.
- rd_data  output  16  load data, registered.
- rd_vld  output  1  one-cycle pulse: rd_data is updated with a completed read.
- stall  output  1  pipeline freeze request; the CPU holds IF/ID..EX/MEM while high.

Behaviour:
- Reset values: rd_data=16'h0000, rd_vld=0, stall=0, state=IDLE, latency counter=0.
- Storage contents are not cleared by reset.
- Reset asserted mid-operation aborts the access immediately:
  - a pending write is not performed;
  - stall drops asynchronously with rst_n low.
- States: IDLE, WAIT, DONE. The state register is 2 bits; the unused encoding returns to IDLE.
- IDLE:
  - stall = re|we, combinational.
  - On a clock edge with re|we=1, latch addr[ADDR_W-1:0], wrt_data, op (write if we=1, else read), and load counter=LAT-1.
  - Next state is WAIT if LAT>1, else DONE.
- WAIT:
  - stall=1.
  - Counter decrements each cycle; at counter==1 the next state is DONE.
  - Inputs are ignored; the latched values are used.
  - Dropping re/we in WAIT does not cancel the access.
- DONE (exactly one cycle):
  - stall=0.
  - Read: rd_data <= mem[latched addr] on entry, and rd_vld=1 for this cycle.
  - Write: mem[latched addr] <= latched data on entry. rd_vld=0 and rd_data holds its value.
  - Next state is always IDLE.
  - A request still visible on re/we during DONE is the already-serviced one and must not be re-accepted. The CPU advances on the DONE edge.
- Timing: a request first seen in cycle T gives stall=1 in cycles T..T+LAT-1 and DONE in cycle T+LAT. Total stall is exactly LAT cycles.
- Back-to-back requests: a new request is seen in the cycle after DONE (IDLE) and is accepted with no extra bubble.
- re and we both high: treated as a write only; no read data is returned and rd_vld stays 0.
- Read-after-write to the same address: the later read returns the newly written data, since the write commits on DONE entry before any later read.
- Addresses alias modulo 2^ADDR_W.
- rd_data is stable between reads; it changes only on read completion.
- With no request, the block stays in IDLE with stall=0 and never toggles rd_vld.

Test Plan:
- Reset: hold rst_n=0 while re=1 -> stall=0, rd_vld=0, rd_data=0. Release -> the request is accepted in the first IDLE cycle and stall rises.
- Write then read, LAT=3: we=1 addr=0x0010 wrt_data=0xBEEF, held until stall drops. Then re=1 addr=0x0010 -> stall high exactly 3 cycles per access. rd_vld pulses once in the read's DONE cycle with rd_data=0xBEEF.
- Input drop: same write, but the bench drives we=0 and addr=0x0020 in the first WAIT cycle. Then read 0x0010 and 0x0020 -> 0x0010 holds the data; 0x0020 is unchanged.
- Simultaneous re&we: re=we=1 addr=5 data=0x1234 -> rd_vld stays 0 and rd_data holds its prior value. A subsequent read of 5 returns 0x1234.
- Aliasing and back-to-back, ADDR_W=12: write 0xA5A5 to 0x1003, then immediately read 0x0003 in the next IDLE cycle -> the read is accepted with no bubble and returns 0xA5A5.
- Mid-operation reset: assert rst_n=0 during WAIT of a write of 0x7777 to addr 9 that previously held 0x0001. Release, then read 9 -> returns 0x0001 (the write was aborted), and stall fell on rst_n low.
